// File: rtl/uart_rx_core.sv
// uart_rx_core
// Receive engine for an 8N1 UART. The line is oversampled 16x through the
// ce_16 enable. Each character is deframed into a byte that is presented with
// a one-clock valid strobe. A stop bit sampled low raises a one-clock
// framing-error strobe instead.
//
// Sample points, counted in ticks after the tick that first sees the line low:
//   start bit qualified at +8, data bit k at +8 + 16*(k+1), stop bit at +152.
// The receiver returns to IDLE at the middle of the stop bit, so a start bit
// that directly follows the stop bit is still caught.

module uart_rx_core (
    input  logic       clock,
    input  logic       reset,
    input  logic       ce_16,
    input  logic       ser_in,
    output logic [7:0] rx_data,
    output logic       new_rx_data,
    output logic       frame_err,
    output logic       rx_busy
);

    // BREAK waits for the line to go high again after a bad stop bit, so a
    // line held low is not decoded as a stream of 0x00 characters.
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    // Two-flop synchronizer on the asynchronous serial line.
    logic       sync_q1;
    logic       in_sync;

    // Current state of the receiver.
    state_t     state;
    logic [3:0] cnt16;     // ticks elapsed inside the current bit
    logic [2:0] bit_cnt;   // index of the next data bit to be sampled
    logic [7:0] shreg;     // data bits collected so far, LSB arrives first

    // Next-state values produced by the combinational block.
    state_t     state_nx;
    logic [3:0] cnt16_nx;
    logic [2:0] bit_cnt_nx;
    logic [7:0] shreg_nx;
    logic [7:0] rx_data_nx;
    logic       new_nx;
    logic       ferr_nx;

    // Bring ser_in into the clock domain; both stages idle high so that
    // reset never looks like a start bit.
    always_ff @(posedge clock) begin
        // NOTE: non-blocking assignments let in_sync take the old sync_q1,
        // giving two real flop stages; blocking here would collapse them.
        if (reset) begin
            sync_q1 <= 1'b1;
            in_sync <= 1'b1;
        end else begin
            sync_q1 <= ser_in;
            in_sync <= sync_q1;
        end
    end

    // Next-state and datapath decisions; nothing moves except on a tick.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no
        // path through the case statement can leave one unassigned and
        // infer a latch.
        state_nx   = state;
        cnt16_nx   = cnt16;
        bit_cnt_nx = bit_cnt;
        shreg_nx   = shreg;
        rx_data_nx = rx_data;
        new_nx     = 1'b0;
        ferr_nx    = 1'b0;

        if (ce_16) begin
            case (state)
                IDLE: begin
                    if (!in_sync) begin
                        state_nx = START;
                        cnt16_nx = 4'd0;
                    end
                end

                START: begin
                    if (cnt16 != 4'd7) begin
                        cnt16_nx = cnt16 + 4'd1;
                    end else if (!in_sync) begin
                        // Still low at mid start bit: a real character.
                        state_nx   = DATA;
                        cnt16_nx   = 4'd0;
                        bit_cnt_nx = 3'd0;
                    end else begin
                        // Glitch shorter than half a bit: ignore it.
                        state_nx = IDLE;
                    end
                end

                DATA: begin
                    if (cnt16 != 4'd15) begin
                        cnt16_nx = cnt16 + 4'd1;
                    end else begin
                        shreg_nx   = {in_sync, shreg[7:1]};
                        cnt16_nx   = 4'd0;
                        bit_cnt_nx = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state_nx = STOP;
                        end
                    end
                end

                STOP: begin
                    if (cnt16 != 4'd15) begin
                        cnt16_nx = cnt16 + 4'd1;
                    end else if (in_sync) begin
                        rx_data_nx = shreg;
                        new_nx     = 1'b1;
                        state_nx   = IDLE;
                    end else begin
                        // Bad stop bit: keep the previous good byte.
                        ferr_nx  = 1'b1;
                        state_nx = BREAK;
                    end
                end

                BREAK: begin
                    if (in_sync) begin
                        state_nx = IDLE;
                    end
                end

                default: begin
                    state_nx = IDLE;
                end
            endcase
        end
    end

    // Receiver state, output byte and registered strobes.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            cnt16       <= 4'd0;
            bit_cnt     <= 3'd0;
            shreg       <= 8'h00;
            rx_data     <= 8'h00;
            new_rx_data <= 1'b0;
            frame_err   <= 1'b0;
            rx_busy     <= 1'b0;
        end else begin
            state       <= state_nx;
            cnt16       <= cnt16_nx;
            bit_cnt     <= bit_cnt_nx;
            shreg       <= shreg_nx;
            rx_data     <= rx_data_nx;
            // Strobes are only set on the sampling tick, so they clear on the
            // very next clock and last exactly one cycle.
            new_rx_data <= new_nx;
            frame_err   <= ferr_nx;
            rx_busy     <= (state_nx != IDLE);
        end
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core
// Self-checking bench for uart_rx_core. A reference decoder works on the
// recorded stream of line values seen at each tick (after the two-clock
// synchronizer delay) and predicts the character / framing-error events.
// Table vectors and hand-written sequences add explicit expectations on top.

module tb_uart_rx_core;

    logic       clock = 1'b0;
    logic       reset;
    logic       ce_16;
    logic       ser_in;
    logic [7:0] rx_data;
    logic       new_rx_data;
    logic       frame_err;
    logic       rx_busy;

    uart_rx_core dut (
        .clock       (clock),
        .reset       (reset),
        .ce_16       (ce_16),
        .ser_in      (ser_in),
        .rx_data     (rx_data),
        .new_rx_data (new_rx_data),
        .frame_err   (frame_err),
        .rx_busy     (rx_busy)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;
    int ce_per  = 1;     // clocks between ce_16 pulses
    int cyc     = 0;     // rising edges seen so far
    int busy_ticks = 0;  // ticks on which rx_busy was high

    typedef struct {
        logic       is_ferr;
        logic [7:0] data;
    } exp_ev_t;

    typedef struct {
        logic       nw;
        logic       fe;
        logic [7:0] data;
        int         cyc;
    } dut_ev_t;

    typedef struct {
        logic [7:0] data;
        logic       stop_hi;
        int         start_t;
        int         bit_t;
        int         ce;
        logic       exp_fe;
        logic [7:0] exp_rx;
        int         exp_lat;   // clocks from start edge to strobe, 0 = skip
    } vec_t;

    exp_ev_t    exp_q[$];
    dut_ev_t    dut_q[$];
    logic       tick_q[$];
    logic       m_s1 = 1'b1;
    logic       m_s2 = 1'b1;
    logic [7:0] model_rx = 8'h00;

    // ce_16 generator: one pulse every ce_per clocks, driven on the falling edge.
    initial begin
        int cnt;
        cnt   = 0;
        ce_16 = 1'b0;
        forever begin
            @(negedge clock);
            if (cnt + 1 >= ce_per) begin
                cnt   = 0;
                ce_16 = 1'b1;
            end else begin
                cnt   = cnt + 1;
                ce_16 = 1'b0;
            end
        end
    end

    // Records the synchronized line value seen on every tick.
    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (reset) begin
            m_s1 <= 1'b1;
            m_s2 <= 1'b1;
        end else begin
            if (ce_16) begin
                tick_q.push_back(m_s2);
                if (rx_busy) busy_ticks <= busy_ticks + 1;
            end
            m_s2 <= m_s1;
            m_s1 <= ser_in;
        end
    end

    // Collects DUT strobes, sampled away from the active edge.
    always @(negedge clock) begin
        if (new_rx_data || frame_err)
            dut_q.push_back('{nw: new_rx_data, fe: frame_err, data: rx_data, cyc: cyc});
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        int c;
        c = 0;
        while (c < n) begin
            @(posedge clock);
            if (ce_16) c++;
        end
    endtask

    task automatic drive(input logic v, input int n);
        @(negedge clock);
        ser_in = v;
        wait_ticks(n);
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop_hi, input int start_t,
                              input int bit_t, input int stop_t, output int start_cyc);
        @(negedge clock);
        ser_in    = 1'b0;
        start_cyc = cyc;
        wait_ticks(start_t);
        for (int k = 0; k < 8; k++) drive(data[k], bit_t);
        drive(stop_hi, stop_t);
    endtask

    task automatic begin_segment();
        tick_q.delete();
        dut_q.delete();
        exp_q.delete();
    endtask

    task automatic flush();
        drive(1'b1, 200);
    endtask

    // Reference decoder over the tick stream. Offsets from the detection tick:
    // start check +8, data bit k at +8+16*(k+1), stop at +152. After a bad
    // stop bit the line must be seen high once before a new start counts.
    task automatic model_decode();
        int n, i, d, j;
        logic [7:0] b;
        exp_q.delete();
        n = tick_q.size();
        i = 0;
        b = 8'h00;
        while (i < n) begin
            if (tick_q[i]) begin
                i++;
            end else begin
                d = i;
                if (d + 152 >= n) begin
                    i = n;
                end else if (tick_q[d + 8]) begin
                    i = d + 9;
                end else begin
                    for (int k = 0; k < 8; k++) b[k] = tick_q[d + 8 + 16 * (k + 1)];
                    if (tick_q[d + 152]) begin
                        exp_q.push_back('{is_ferr: 1'b0, data: b});
                        model_rx = b;
                        i = d + 153;
                    end else begin
                        exp_q.push_back('{is_ferr: 1'b1, data: model_rx});
                        j = d + 153;
                        while (j < n && !tick_q[j]) j++;
                        i = j + 1;
                    end
                end
            end
        end
    endtask

    task automatic compare_model(input string tag);
        int m;
        model_decode();
        check({tag, "_count"}, 32'(dut_q.size()), 32'(exp_q.size()));
        m = (dut_q.size() < exp_q.size()) ? dut_q.size() : exp_q.size();
        for (int i = 0; i < m; i++) begin
            check($sformatf("%s_ev%0d_ferr", tag, i), 32'(dut_q[i].fe), 32'(exp_q[i].is_ferr));
            check($sformatf("%s_ev%0d_new", tag, i), 32'(dut_q[i].nw), 32'(!exp_q[i].is_ferr));
            check($sformatf("%s_ev%0d_data", tag, i), 32'(dut_q[i].data), 32'(exp_q[i].data));
        end
    endtask

    initial begin
        vec_t vt[6];
        int   sc;
        int   b0;
        int   bt;

        vt[0] = '{8'hC3, 1'b1, 16, 15, 1, 1'b0, 8'hC3, 155};
        vt[1] = '{8'h3C, 1'b1, 16, 17, 1, 1'b0, 8'h3C, 155};
        vt[2] = '{8'h00, 1'b1, 16, 16, 2, 1'b0, 8'h00, 0};
        vt[3] = '{8'h80, 1'b0, 16, 16, 3, 1'b1, 8'h00, 0};
        vt[4] = '{8'h7E, 1'b1, 16, 16, 3, 1'b0, 8'h7E, 0};
        vt[5] = '{8'hA5, 1'b1, 16, 16, 4, 1'b0, 8'hA5, 0};

        // Reset state, with the line held low throughout reset.
        reset  = 1'b1;
        ser_in = 1'b0;
        ce_per = 1;
        repeat (3) @(negedge clock);
        check("rst_rx_data", 32'(rx_data), 32'h00);
        check("rst_new", 32'(new_rx_data), 32'h0);
        check("rst_ferr", 32'(frame_err), 32'h0);
        check("rst_busy", 32'(rx_busy), 32'h0);
        reset  = 1'b0;
        ser_in = 1'b1;
        repeat (3) @(negedge clock);
        check("rst_sync_idle_high", 32'(rx_busy), 32'h0);

        // Table vectors: one frame each, explicit expectations plus model.
        for (int i = 0; i < 6; i++) begin
            ce_per = vt[i].ce;
            begin_segment();
            send_frame(vt[i].data, vt[i].stop_hi, vt[i].start_t, vt[i].bit_t, 16, sc);
            flush();
            compare_model($sformatf("vec%0d", i));
            if (dut_q.size() >= 1) begin
                check($sformatf("vec%0d_fe", i), 32'(dut_q[0].fe), 32'(vt[i].exp_fe));
                check($sformatf("vec%0d_data", i), 32'(dut_q[0].data), 32'(vt[i].exp_rx));
                if (vt[i].exp_lat != 0)
                    check($sformatf("vec%0d_latency", i), 32'(dut_q[0].cyc - sc), 32'(vt[i].exp_lat));
            end
            check($sformatf("vec%0d_events", i), 32'(dut_q.size()), 32'd1);
            check($sformatf("vec%0d_rx_hold", i), 32'(rx_data), 32'(vt[i].exp_rx));
            check($sformatf("vec%0d_busy_end", i), 32'(rx_busy), 32'h0);
        end

        // Glitch: 4 low ticks, then high.
        ce_per = 4;
        begin_segment();
        b0 = busy_ticks;
        drive(1'b0, 4);
        flush();
        bt = busy_ticks - b0;
        compare_model("glitch");
        check("glitch_events", 32'(dut_q.size()), 32'd0);
        check("glitch_busy_1_to_8", 32'(bt >= 1 && bt <= 8), 32'd1);
        check("glitch_rx_hold", 32'(rx_data), 32'hA5);

        // Framing error, line held low, then a good 0x11.
        begin_segment();
        send_frame(8'h3C, 1'b0, 16, 16, 16, sc);
        drive(1'b0, 40);
        drive(1'b1, 20);
        send_frame(8'h11, 1'b1, 16, 16, 16, sc);
        flush();
        compare_model("brk");
        check("brk_events", 32'(dut_q.size()), 32'd2);
        if (dut_q.size() == 2) begin
            check("brk_ferr", 32'(dut_q[0].fe), 32'h1);
            check("brk_rx_kept", 32'(dut_q[0].data), 32'hA5);
            check("brk_next_new", 32'(dut_q[1].nw), 32'h1);
            check("brk_next_data", 32'(dut_q[1].data), 32'h11);
        end

        // Back-to-back 0x00 then 0xFF, 16-tick stop, no idle gap.
        begin_segment();
        send_frame(8'h00, 1'b1, 16, 16, 16, sc);
        send_frame(8'hFF, 1'b1, 16, 16, 16, sc);
        flush();
        compare_model("b2b");
        check("b2b_events", 32'(dut_q.size()), 32'd2);
        if (dut_q.size() == 2) begin
            check("b2b_first", 32'(dut_q[0].data), 32'h00);
            check("b2b_second", 32'(dut_q[1].data), 32'hFF);
        end

        // Reset during data bit 4, then 0x5A.
        begin_segment();
        drive(1'b0, 16);
        for (int k = 0; k < 4; k++) drive(1'b1, 16);
        drive(1'b1, 8);
        check("midrst_busy_before", 32'(rx_busy), 32'h1);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("midrst_rx_data", 32'(rx_data), 32'h00);
        check("midrst_new", 32'(new_rx_data), 32'h0);
        check("midrst_ferr", 32'(frame_err), 32'h0);
        check("midrst_busy", 32'(rx_busy), 32'h0);
        model_rx = 8'h00;
        begin_segment();
        send_frame(8'h5A, 1'b1, 16, 16, 16, sc);
        flush();
        compare_model("midrst");
        check("midrst_events", 32'(dut_q.size()), 32'd1);
        if (dut_q.size() == 1)
            check("midrst_data", 32'(dut_q[0].data), 32'h5A);

        // Randomized traffic against the reference decoder.
        begin_segment();
        for (int f = 0; f < 30; f++) begin
            int   bw;
            logic sh;
            ce_per = $urandom_range(1, 4);
            if ($urandom_range(0, 9) == 0) begin
                drive(1'b0, $urandom_range(1, 7));
                drive(1'b1, $urandom_range(2, 10));
            end else begin
                bw = $urandom_range(15, 17);
                sh = ($urandom_range(0, 4) != 0);
                send_frame(8'($urandom), sh, bw, bw, $urandom_range(9, 20), sc);
                if (!sh) drive(1'b0, $urandom_range(0, 30));
                drive(1'b1, $urandom_range(0, 12));
            end
        end
        flush();
        compare_model("rnd");
        check("rnd_busy_end", 32'(rx_busy), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
